vin_raster_gen: RTL and testbench
=================================

# vin_raster_gen

Parametrised raster timing generator for the VIN video block family. It generalises the fixed 4×56×(262/312) window timing into configurable clock division, windows per line, lines per field and visible band, and adds external vertical lock on SYT. It also adds a field-synchronous mode switch and character row/slice/column counters. It sits between the clock source and the display/access automata: it tells them when the bus belongs to display fetches and which row, slice and column to fetch.

## Interface
- CLK_DIV, 4: clocks per window; power of two, ≥2.
- WIN_PER_LINE, 56: windows per line.
- VIS_FIRST, 12: first visible window.
- VIS_COLS, 40: visible windows per line.
- LINES_50, 312: lines per field in 50 Hz mode.
- LINES_60, 262: lines per field in 60 Hz mode.
- VSTART_50, 40: first visible line in 50 Hz mode.
- VSTART_60, 14: first visible line in 60 Hz mode.
- ROWS, 24: character rows.
- SLICES, 10: slices per row.
- VS_W, 2: tt low width, in lines.
- HS_W, 4: tl low width, in windows (TV mode).
- SYT_WIN, 12: window at which SYT is sampled.

Ports:
- clk  in  1  system clock (3.5 MHz nominal)
- res  in  1  asynchronous, active-high reset
- mode_50hz  in  1  field standard request; adopted only at field start
- monitor  in  1  tl shape select
- display_en  in  1  enables bus_en
- syt  in  1  external vertical sync; asynchronous
- phase  out  $clog2(CLK_DIV)  clock index within window
- win_last  out  1  high on last clock of each window
- tf  out  $clog2(WIN_PER_LINE)  window counter
- line  out  9  line counter
- tl  out  1  horizontal sync
- tt  out  1  vertical sync
- bus_en  out  1  display automaton owns the bus
- col  out  6  visible column, 0..VIS_COLS-1
- row  out  5  character row, 0..ROWS-1
- slice  out  4  slice within row, 0..SLICES-1
- field_start  out  1  one-clock pulse when line wraps to 0
- locked  out  1  SYT edges coincide with natural field wrap

## Operation
- phase increments every clock. win_last = (phase==CLK_DIV-1).
- On win_last, tf increments. At WIN_PER_LINE-1, tf wraps to 0 and the line-end event fires.
- On line-end:
  - If a pending SYT wrap exists, or line==NL-1, line goes to 0. NL is LINES_50 or LINES_60 per the active mode.
  - Otherwise line increments.
- Active mode register:
  - Loaded from mode_50hz only when line goes to 0.
  - A mode change mid-field has no effect until the next wrap.
- SYT path:
  - Two-flop synchroniser, then a registered sample taken on win_last when tf==SYT_WIN.
  - A falling edge between consecutive samples sets a pending flag. The flag is consumed at the next line-end.
- locked:
  - Set at an SYT-forced wrap when line==NL-1 at that moment.
  - Cleared at an SYT-forced wrap on any other line.
  - Cleared when two consecutive natural wraps occur with no SYT edge.
- Visible band:
  - vis_line = line in [VSTART, VSTART+ROWS*SLICES-1], using VSTART for the active mode.
  - vis_win = tf in [VIS_FIRST, VIS_FIRST+VIS_COLS-1].
  - bus_en = display_en & vis_line & vis_win.
- Character counters:
  - col = tf−VIS_FIRST inside vis_win, else 0.
  - slice/row reset to 0 on the line-end that enters line VSTART.
  - On each later line-end inside the band, slice increments. At SLICES-1, slice wraps to 0 and row increments.
  - Outside the band, row and slice hold 0.
- tl:
  - monitor=1: tl high when tf<VIS_FIRST or tf≥VIS_FIRST+VIS_COLS, else low.
  - monitor=0: tl low when tf<HS_W, else high.
- tt is low while line<VS_W.
- Reset, asynchronous: phase, tf, line, col, row, slice, field_start, locked, bus_en, pending flag and SYT samples all go to 0. Mode register goes to 1 (50 Hz). tl is reset to 0. tt is reset to 0, because line 0 lies in the sync band.

## Timing
- All outputs are registered and reflect counter state in the same clock the counters take the value.
- bus_en and col change on the clock where tf changes.
- win_last is high when phase==CLK_DIV-1 and low otherwise.
- field_start is high for exactly one clock: the first clock with line==0 after a wrap. It is not pulsed on reset.
- SYT latency: the pad edge becomes the pending flag within 2 clocks plus up to one line. The line wrap occurs at the end of the line containing the SYT_WIN sample.
- An SYT edge during line NL-1 coincides with the natural wrap. The result is one wrap, not two.
- An SYT edge and the end of the visible band in the same line: line goes to 0 and row/slice go to 0.
- A res assertion mid-window aborts immediately. The first window after release starts at phase 0, tf 0.

## Test plan
- Defaults, mode_50hz=1, display_en=1, no SYT. Required:
  - win_last period 4 clocks; tf wraps 55→0.
  - line wraps 311→0 and field_start pulses once per 69888 clocks.
  - tt is low for lines 0–1.
- Same settings, bus_en count. Required: bus_en high for 40 windows on lines 40–279; total 240 lines. Lines 39 and 280: never.
- Row/slice sweep. Required: on line 40, row=0, slice=0. On line 49, slice=9. On line 50, row=1, slice=0. On line 279, row=23, slice=9.
- mode_50hz toggled to 0 at line 100. Required: wrap still at 311. The next field wraps at 261 and the visible band is lines 14–253.
- syt falls while line 150 passes tf=12. Required: line goes to 0 after line 150 and locked=0. A falling edge during line 311 gives a single wrap and locked=1.
- monitor=1 against monitor=0. Required: monitor=1 gives tl high for tf 0–11 and 52–55. monitor=0 gives tl low only for tf 0–3. Asserting res at phase 2 forces all counters to 0 within one clock.

Source files
------------

// File: rtl/vin_raster_gen.sv
// rtl/vin_raster_gen.sv - parametrised raster timing generator with SYT vertical lock
//
// Purpose: derives window, line and character-cell timing from the system clock,
// tells the display/access automata when the bus belongs to display fetches and
// which column/row/slice to fetch, and optionally slaves the field to an external
// vertical sync (SYT).
//
// Ports:
//   clk, res      clock and asynchronous active-high reset
//   mode_50hz     field standard request, taken only when the line counter wraps
//   monitor       tl shape select (1: blank-window shape, 0: TV sync pulse)
//   display_en    gates bus_en
//   syt           external vertical sync, asynchronous, falling edge forces a wrap
//   phase         clock index within the current window
//   win_last      high on the last clock of each window
//   tf, line      window and line counters
//   tl, tt        horizontal and vertical sync
//   bus_en        display automaton owns the bus
//   col/row/slice character-cell position inside the visible band
//   field_start   one-clock pulse on the first clock of line 0 after a wrap
//   locked        SYT edges coincide with the natural field wrap
module vin_raster_gen #(
  parameter int CLK_DIV      = 4,
  parameter int WIN_PER_LINE = 56,
  parameter int VIS_FIRST    = 12,
  parameter int VIS_COLS     = 40,
  parameter int LINES_50     = 312,
  parameter int LINES_60     = 262,
  parameter int VSTART_50    = 40,
  parameter int VSTART_60    = 14,
  parameter int ROWS         = 24,
  parameter int SLICES       = 10,
  parameter int VS_W         = 2,
  parameter int HS_W         = 4,
  parameter int SYT_WIN      = 12
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic                            mode_50hz,
  input  logic                            monitor,
  input  logic                            display_en,
  input  logic                            syt,
  output logic [$clog2(CLK_DIV)-1:0]      phase,
  output logic                            win_last,
  output logic [$clog2(WIN_PER_LINE)-1:0] tf,
  output logic [8:0]                      line,
  output logic                            tl,
  output logic                            tt,
  output logic                            bus_en,
  output logic [5:0]                      col,
  output logic [4:0]                      row,
  output logic [3:0]                      slice,
  output logic                            field_start,
  output logic                            locked
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int TW = $clog2(WIN_PER_LINE);

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TF_LAST  = TW'(WIN_PER_LINE - 1);
  localparam logic [TW-1:0] TF_SYT   = TW'(SYT_WIN);
  localparam logic [TW-1:0] TF_VIS0  = TW'(VIS_FIRST);
  localparam logic [TW-1:0] TF_VIS1  = TW'(VIS_FIRST + VIS_COLS - 1);
  localparam logic [TW-1:0] TF_HS    = TW'(HS_W);
  localparam logic [8:0]    NL50_END = 9'(LINES_50 - 1);
  localparam logic [8:0]    NL60_END = 9'(LINES_60 - 1);
  localparam logic [8:0]    VS50     = 9'(VSTART_50);
  localparam logic [8:0]    VE50     = 9'(VSTART_50 + ROWS * SLICES - 1);
  localparam logic [8:0]    VS60     = 9'(VSTART_60);
  localparam logic [8:0]    VE60     = 9'(VSTART_60 + ROWS * SLICES - 1);
  localparam logic [8:0]    VSW      = 9'(VS_W);
  localparam logic [3:0]    SL_LAST  = 4'(SLICES - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] tf_q, tf_d;
  logic [8:0]    line_q, line_d;
  logic          mode_q, mode_d;
  logic          sync1_q, sync2_q;
  logic          smp_q, smp_d;
  logic          pend_q, pend_d;
  logic          locked_q, locked_d;
  logic          nat_q, nat_d;
  logic          win_last_q, win_last_d;
  logic          tl_q, tl_d;
  logic          tt_q, tt_d;
  logic          bus_en_q, bus_en_d;
  logic [5:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [3:0]    slice_q, slice_d;
  logic          fs_q, fs_d;

  logic          win_end, line_end, wrap, smp_pt;
  logic [8:0]    nl_end, vs, ve;
  logic          vis_line_d, vis_win_d;

  always_comb begin
    win_end  = (phase_q == PH_LAST);
    line_end = win_end && (tf_q == TF_LAST);
    nl_end   = mode_q ? NL50_END : NL60_END;
    // A pending SYT edge and the natural last line collapse into a single wrap.
    wrap     = line_end && (pend_q || (line_q == nl_end));
    smp_pt   = win_end && (tf_q == TF_SYT);

    // CLK_DIV is a power of two, so the phase counter wraps on its own.
    phase_d = phase_q + PW'(1);

    tf_d = tf_q;
    if (win_end) begin
      tf_d = (tf_q == TF_LAST) ? '0 : tf_q + TW'(1);
    end

    line_d = line_q;
    if (wrap) begin
      line_d = '0;
    end else if (line_end) begin
      line_d = line_q + 9'd1;
    end

    mode_d = wrap ? mode_50hz : mode_q;

    // Falling edge seen between two consecutive once-per-line samples.
    smp_d  = smp_pt ? sync2_q : smp_q;
    pend_d = pend_q;
    if (line_end) begin
      pend_d = 1'b0;
    end else if (smp_pt && smp_q && !sync2_q) begin
      pend_d = 1'b1;
    end

    locked_d = locked_q;
    nat_d    = nat_q;
    if (wrap) begin
      if (pend_q) begin
        locked_d = (line_q == nl_end);
        nat_d    = 1'b0;
      end else begin
        if (nat_q) begin
          locked_d = 1'b0;
        end
        nat_d = 1'b1;
      end
    end

    // Registered outputs are derived from next-state counters so they line up
    // with the counters in the same clock.
    vs         = mode_d ? VS50 : VS60;
    ve         = mode_d ? VE50 : VE60;
    vis_line_d = (line_d >= vs) && (line_d <= ve);
    vis_win_d  = (tf_d >= TF_VIS0) && (tf_d <= TF_VIS1);

    row_d   = row_q;
    slice_d = slice_q;
    if (line_end) begin
      if (line_d == vs) begin
        row_d   = '0;
        slice_d = '0;
      end else if (vis_line_d) begin
        if (slice_q == SL_LAST) begin
          slice_d = '0;
          row_d   = row_q + 5'd1;
        end else begin
          slice_d = slice_q + 4'd1;
        end
      end else begin
        row_d   = '0;
        slice_d = '0;
      end
    end

    col_d      = vis_win_d ? 6'(tf_d - TF_VIS0) : 6'd0;
    tl_d       = monitor ? !vis_win_d : (tf_d >= TF_HS);
    tt_d       = (line_d >= VSW);
    bus_en_d   = display_en && vis_line_d && vis_win_d;
    win_last_d = (phase_d == PH_LAST);
    fs_d       = wrap;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      phase_q    <= '0;
      tf_q       <= '0;
      line_q     <= '0;
      mode_q     <= 1'b1;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      smp_q      <= 1'b0;
      pend_q     <= 1'b0;
      locked_q   <= 1'b0;
      nat_q      <= 1'b0;
      win_last_q <= 1'b0;
      tl_q       <= 1'b0;
      tt_q       <= 1'b0;
      bus_en_q   <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      slice_q    <= '0;
      fs_q       <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      tf_q       <= tf_d;
      line_q     <= line_d;
      mode_q     <= mode_d;
      sync1_q    <= syt;
      sync2_q    <= sync1_q;
      smp_q      <= smp_d;
      pend_q     <= pend_d;
      locked_q   <= locked_d;
      nat_q      <= nat_d;
      win_last_q <= win_last_d;
      tl_q       <= tl_d;
      tt_q       <= tt_d;
      bus_en_q   <= bus_en_d;
      col_q      <= col_d;
      row_q      <= row_d;
      slice_q    <= slice_d;
      fs_q       <= fs_d;
    end
  end

  assign phase       = phase_q;
  assign win_last    = win_last_q;
  assign tf          = tf_q;
  assign line        = line_q;
  assign tl          = tl_q;
  assign tt          = tt_q;
  assign bus_en      = bus_en_q;
  assign col         = col_q;
  assign row         = row_q;
  assign slice       = slice_q;
  assign field_start = fs_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_vin_raster_gen.sv
// tb/tb_vin_raster_gen.sv - self-checking bench for vin_raster_gen
module tb_vin_raster_gen;

  localparam int CD    = 4;
  localparam int WPL   = 16;
  localparam int VF    = 4;
  localparam int VC    = 8;
  localparam int L50   = 24;
  localparam int L60   = 20;
  localparam int VS50  = 5;
  localparam int VS60  = 3;
  localparam int ROWS  = 3;
  localparam int SL    = 4;
  localparam int VSW   = 2;
  localparam int HSW   = 2;
  localparam int SYTW  = 6;
  localparam int CPL   = CD * WPL;

  logic       clk, res, mode_50hz, monitor, display_en, syt;
  logic [1:0] phase;
  logic       win_last;
  logic [3:0] tf;
  logic [8:0] line;
  logic       tl, tt, bus_en;
  logic [5:0] col;
  logic [4:0] row;
  logic [3:0] slice;
  logic       field_start, locked;

  vin_raster_gen #(
    .CLK_DIV(CD), .WIN_PER_LINE(WPL), .VIS_FIRST(VF), .VIS_COLS(VC),
    .LINES_50(L50), .LINES_60(L60), .VSTART_50(VS50), .VSTART_60(VS60),
    .ROWS(ROWS), .SLICES(SL), .VS_W(VSW), .HS_W(HSW), .SYT_WIN(SYTW)
  ) dut (
    .clk(clk), .res(res), .mode_50hz(mode_50hz), .monitor(monitor),
    .display_en(display_en), .syt(syt), .phase(phase), .win_last(win_last),
    .tf(tf), .line(line), .tl(tl), .tt(tt), .bus_en(bus_en), .col(col),
    .row(row), .slice(slice), .field_start(field_start), .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: position inside the field as a plain clock count; every
  // counter value is derived from it arithmetically.
  int m_t, m_nat;
  bit m_mode, m_pend, m_prev, m_locked, m_fs, m_h1, m_h2;
  bit rnd_mode = 0;
  int prev_line = 0, last_obs_line = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_nat = 0; m_mode = 1; m_pend = 0; m_prev = 0;
    m_locked = 0; m_fs = 0; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic model_step();
    int ph, w, ln, nl;
    ph = m_t % CD;
    w  = (m_t / CD) % WPL;
    ln = m_t / CPL;
    m_fs = 0;
    if (ph == CD - 1 && w == SYTW) begin
      if (m_prev && !m_h2) m_pend = 1;
      m_prev = m_h2;
    end
    m_h2 = m_h1;
    m_h1 = syt;
    nl = m_mode ? L50 : L60;
    if (ph == CD - 1 && w == WPL - 1 && (m_pend || ln == nl - 1)) begin
      if (m_pend) begin
        m_locked = (ln == nl - 1);
        m_nat = 0;
      end else begin
        m_nat++;
        if (m_nat >= 2) m_locked = 0;
      end
      m_mode = mode_50hz;
      m_pend = 0;
      m_t = 0;
      m_fs = 1;
    end else begin
      if (ph == CD - 1 && w == WPL - 1) m_pend = 0;
      m_t++;
    end
  endtask

  task automatic check_all();
    int ph, w, ln, vs;
    bit vl, vw;
    ph = m_t % CD;
    w  = (m_t / CD) % WPL;
    ln = m_t / CPL;
    vs = m_mode ? VS50 : VS60;
    vl = (ln >= vs) && (ln < vs + ROWS * SL);
    vw = (w >= VF) && (w < VF + VC);
    chk("phase", 32'(phase), 32'(ph));
    chk("win_last", 32'(win_last), 32'(ph == CD - 1));
    chk("tf", 32'(tf), 32'(w));
    chk("line", 32'(line), 32'(ln));
    chk("tl", 32'(tl), 32'(monitor ? !vw : (w >= HSW)));
    chk("tt", 32'(tt), 32'(ln >= VSW));
    chk("bus_en", 32'(bus_en), 32'(display_en && vl && vw));
    chk("col", 32'(col), vw ? 32'(w - VF) : 32'd0);
    chk("row", 32'(row), vl ? 32'((ln - vs) / SL) : 32'd0);
    chk("slice", 32'(slice), vl ? 32'((ln - vs) % SL) : 32'd0);
    chk("field_start", 32'(field_start), 32'(m_fs));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic tick(input bit rnd = 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    prev_line = last_obs_line;
    last_obs_line = int'(line);
    if (rnd) begin
      monitor    = 1'($urandom_range(0, 1));
      display_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) syt = ~syt;
      if (rnd_mode && $urandom_range(0, 299) == 0) mode_50hz = ~mode_50hz;
    end
  endtask

  task automatic run_to(input int tgt);
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_t == tgt) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("run_to_reached", 32'(ok), 32'd1);
  endtask

  int f_clks, f_bus, f_last, f_first_bl, f_last_bl;

  task automatic run_field();
    bit ok = 0;
    f_clks = 0; f_bus = 0; f_last = -1; f_first_bl = -1; f_last_bl = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      f_clks++;
      if (bus_en === 1'b1) begin
        f_bus++;
        if (f_first_bl < 0) f_first_bl = int'(line);
        f_last_bl = int'(line);
      end
      if (field_start === 1'b1) begin
        ok = 1;
        f_last = prev_line;
        break;
      end
    end
    chk("field_wrap_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    res = 1'b1; mode_50hz = 1'b1; monitor = 1'b0; display_en = 1'b1; syt = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_tf", 32'(tf), 0);
    chk("rst_line", 32'(line), 0);
    chk("rst_win_last", 32'(win_last), 0);
    chk("rst_tl", 32'(tl), 0);
    chk("rst_tt", 32'(tt), 0);
    chk("rst_bus_en", 32'(bus_en), 0);
    chk("rst_col", 32'(col), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_slice", 32'(slice), 0);
    chk("rst_field_start", 32'(field_start), 0);
    chk("rst_locked", 32'(locked), 0);
    res = 1'b0;

    // 50 Hz field from reset, TV sync shape
    run_field();
    chk("f50_clocks", 32'(f_clks), 32'(L50 * CPL));
    chk("f50_bus_clocks", 32'(f_bus), 32'(VC * ROWS * SL * CD));
    chk("f50_last_line", 32'(f_last), 32'(L50 - 1));
    chk("f50_first_bus_line", 32'(f_first_bl), 32'(VS50));
    chk("f50_last_bus_line", 32'(f_last_bl), 32'(VS50 + ROWS * SL - 1));

    // monitor-shaped tl over a whole field
    monitor = 1'b1;
    run_field();
    chk("mon_clocks", 32'(f_clks), 32'(L50 * CPL));
    monitor = 1'b0;

    // mode change mid-field takes effect only at the next wrap
    run_to(10 * CPL);
    mode_50hz = 1'b0;
    run_field();
    chk("modechg_last_line", 32'(f_last), 32'(L50 - 1));
    run_field();
    chk("f60_clocks", 32'(f_clks), 32'(L60 * CPL));
    chk("f60_last_line", 32'(f_last), 32'(L60 - 1));
    chk("f60_bus_clocks", 32'(f_bus), 32'(VC * ROWS * SL * CD));
    chk("f60_first_bus_line", 32'(f_first_bl), 32'(VS60));
    chk("f60_last_bus_line", 32'(f_last_bl), 32'(VS60 + ROWS * SL - 1));

    // SYT falling mid-field forces an early wrap, not locked
    run_to(8 * CPL + CD);
    syt = 1'b0;
    run_field();
    chk("syt_early_last_line", 32'(f_last), 32'd8);
    chk("syt_early_locked", 32'(locked), 32'd0);
    syt = 1'b1;
    // SYT falling on the last line merges with the natural wrap
    run_to((L60 - 1) * CPL + CD);
    syt = 1'b0;
    run_field();
    chk("syt_lock_last_line", 32'(f_last), 32'(L60 - 1));
    chk("syt_lock_locked", 32'(locked), 32'd1);
    run_field();
    chk("single_wrap_clocks", 32'(f_clks), 32'(L60 * CPL));
    chk("nat1_locked", 32'(locked), 32'd1);
    run_field();
    chk("nat2_locked", 32'(locked), 32'd0);

    // randomized inputs against the model
    rnd_mode = 1;
    for (int i = 0; i < 4000; i++) tick(1);
    rnd_mode = 0;
    monitor = 1'b0; display_en = 1'b1;

    // reset asserted mid-window clears everything without a clock
    begin
      bit ok = 0;
      for (int i = 0; i < 16; i++) begin
        if (m_t % CD == 2 && m_t > CPL) begin
          ok = 1;
          break;
        end
        tick();
      end
      chk("phase2_reached", 32'(ok), 32'd1);
    end
    res = 1'b1;
    #1;
    chk("mid_rst_phase", 32'(phase), 0);
    chk("mid_rst_tf", 32'(tf), 0);
    chk("mid_rst_line", 32'(line), 0);
    chk("mid_rst_col", 32'(col), 0);
    chk("mid_rst_row", 32'(row), 0);
    chk("mid_rst_slice", 32'(slice), 0);
    chk("mid_rst_tt", 32'(tt), 0);
    chk("mid_rst_locked", 32'(locked), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    mode_50hz = 1'b1;
    for (int i = 0; i < 3 * CPL; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
